apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_mem_slave.sv | 146 ++++++++++++++
 tb/tb_apb_mem_slave.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
`timescale 1ns/1ps
// APB slave backed by a DATA_W x DEPTH memory with wait states, error response and an
// optional read-only upper region. Define APB_MEM_PSTRB_EN to add byte-lane strobes (PSTRB).
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int RO_BASE     = DEPTH
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NBYTES - 1);
  localparam logic [63:0]       MEM_BYTES  = 64'(DEPTH) * 64'(NBYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              latch;
  logic [IDX_W-1:0]  idx_in, idx_q, rd_idx;
  logic              write_q, err_q, err_in, resp_err, resp_write;
  logic [DATA_W-1:0] wdata_q, wr_word, rdata_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef APB_MEM_PSTRB_EN
  logic [NBYTES-1:0] strb_q;
`endif

  assign idx_in = PADDR[LSB +: IDX_W];

  // Errors are decided once, from the setup-cycle bus values, and carried with the transfer.
  always_comb begin
    err_in = (|(PADDR & ALIGN_MASK))
          || (64'(PADDR) >= MEM_BYTES)
          || (PWRITE && (int'(idx_in) >= RO_BASE));
`ifdef APB_MEM_PSTRB_EN
    err_in = err_in || (!PWRITE && (|PSTRB));
`endif
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          latch   = 1'b1;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no wait states RESP follows the setup edge, so the response uses the bus values directly.
  always_comb begin
    resp_err   = latch ? err_in : err_q;
    resp_write = latch ? PWRITE : write_q;
    rd_idx     = latch ? idx_in : idx_q;
    rdata_d    = '0;
    if (state_d == RESP && !resp_err && !resp_write) rdata_d = mem[rd_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
`ifdef APB_MEM_PSTRB_EN
      strb_q  <= '0;
`endif
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        idx_q   <= idx_in;
        write_q <= PWRITE;
        err_q   <= err_in;
        wdata_q <= PWDATA;
`ifdef APB_MEM_PSTRB_EN
        strb_q  <= PSTRB;
`endif
      end
      PREADY  <= (state_d == RESP);
      PSLVERR <= (state_d == RESP) && resp_err;
      PRDATA  <= rdata_d;
    end
  end

  always_comb begin
`ifdef APB_MEM_PSTRB_EN
    wr_word = mem[idx_q];
    for (int b = 0; b < NBYTES; b++) begin
      if (strb_q[b]) wr_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
`else
    wr_word = wdata_q;
`endif
  end

  // Commit at the edge that ends RESP, unless the master dropped PSEL or reset is active.
  assign mem_we = PRESETn && (state_q == RESP) && PSEL && write_q && !err_q;

  // NOTE: the memory array has no reset; contents survive PRESETn and map onto plain RAM.
  always_ff @(posedge PCLK) begin
    if (mem_we) mem[idx_q] <= wr_word;
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
`timescale 1ns/1ps
// Directed self-checking bench for apb_mem_slave: three instances (defaults, 3 wait states with
// read-only upper half, 2 wait states) on a shared APB bus with one PSEL per instance.
module tb_apb_mem_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pready, pslverr;
  logic [31:0] prdata [3];
`ifdef APB_MEM_PSTRB_EN
  logic [3:0]  pstrb;
  logic [3:0]  wr_strb = 4'hF;
  logic [3:0]  rd_strb = 4'h0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  apb_mem_slave u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_mem_slave #(.WAIT_STATES(3), .RO_BASE(512)) u_dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  apb_mem_slave #(.WAIT_STATES(2)) u_dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Setup then access; the bus is scrambled after setup so only latched values may matter.
  // Returns at the falling edge of the PREADY cycle with the bus still in access phase.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata, output logic err, output int lat);
    @(negedge PCLK);
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
`ifdef APB_MEM_PSTRB_EN
    pstrb   = wr ? wr_strb : rd_strb;
`endif
    @(negedge PCLK);
    penable = 1'b1;
    paddr   = ~addr;
    pwdata  = ~data;
    pwrite  = ~wr;
`ifdef APB_MEM_PSTRB_EN
    pstrb   = ~pstrb;
`endif
    lat = 1;
    while (pready[d] !== 1'b1 && lat < 40) begin
      @(negedge PCLK);
      lat++;
    end
    rdata = prdata[d];
    err   = pslverr[d];
  endtask

  task automatic bus_idle();
    @(negedge PCLK);
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, old;
    logic        er, seen;
    int          lat;

    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_MEM_PSTRB_EN
    pstrb = 4'h0;
`endif
    #23;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_pready%0d", i),  32'(pready[i]), 32'd0);
      check($sformatf("reset_pslverr%0d", i), 32'(pslverr[i]), 32'd0);
      check($sformatf("reset_prdata%0d", i),  prdata[i], 32'd0);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Defaults: write then back-to-back read of the same word.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("d0_wr_latency", 32'(lat), 32'd1);
    check("d0_wr_pslverr", 32'(er), 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, er, lat);
    check("d0_rd_latency", 32'(lat), 32'd1);
    check("d0_rd_data",    rd, 32'hDEADBEEF);
    check("d0_rd_pslverr", 32'(er), 32'd0);
    bus_idle();
    check("d0_idle_pready", 32'(pready[0]), 32'd0);
    check("d0_idle_prdata", prdata[0], 32'd0);

    // PENABLE without a setup cycle is ignored.
    psel[0] = 1'b1; penable = 1'b1; paddr = 32'h10; pwrite = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      seen = seen | pready[0];
    end
    check("d0_no_setup_pready", 32'(seen), 32'd0);
    bus_idle();

    // Out-of-range and misaligned reads.
    xfer(0, 1'b0, 32'h1000, 32'h0, rd, er, lat);
    check("d0_oor_pslverr", 32'(er), 32'd1);
    check("d0_oor_prdata",  rd, 32'd0);
    bus_idle();
    xfer(0, 1'b0, 32'h12, 32'h0, rd, er, lat);
    check("d0_misalign_pslverr", 32'(er), 32'd1);
    check("d0_misalign_prdata",  rd, 32'd0);
    bus_idle();
    check("d0_pslverr_after", 32'(pslverr[0]), 32'd0);

    // Three wait states, read-only region from word 512.
    xfer(1, 1'b0, 32'h800, 32'h0, old, er, lat);
    check("d1_rd_latency", 32'(lat), 32'd4);
    check("d1_rd_pslverr", 32'(er), 32'd0);
    @(negedge PCLK);
    check("d1_pready_one_cycle", 32'(pready[1]), 32'd0);
    bus_idle();
    xfer(1, 1'b1, 32'h800, ~old, rd, er, lat);
    check("d1_ro_wr_latency", 32'(lat), 32'd4);
    check("d1_ro_wr_pslverr", 32'(er), 32'd1);
    bus_idle();
    xfer(1, 1'b0, 32'h800, 32'h0, rd, er, lat);
    check("d1_ro_unchanged", rd, old);
    bus_idle();
    xfer(1, 1'b1, 32'h7FC, 32'h0BADCAFE, rd, er, lat);
    check("d1_rw_wr_pslverr", 32'(er), 32'd0);
    xfer(1, 1'b0, 32'h7FC, 32'h0, rd, er, lat);
    check("d1_rw_rd_data", rd, 32'h0BADCAFE);
    bus_idle();

    // Two wait states: baseline write, then abort by dropping PSEL in the second access cycle.
    xfer(2, 1'b1, 32'h20, 32'h12345678, rd, er, lat);
    check("d2_wr_latency", 32'(lat), 32'd3);
    bus_idle();
    @(negedge PCLK);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hFFFF0000;
    @(negedge PCLK);
    penable = 1'b1;
    seen = pready[2];
    @(negedge PCLK);
    psel = 3'b000; penable = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      seen = seen | pready[2] | pslverr[2];
    end
    check("d2_abort_no_pready", 32'(seen), 32'd0);
    xfer(2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("d2_abort_mem", rd, 32'h12345678);
    check("d2_abort_next_latency", 32'(lat), 32'd3);
    bus_idle();

    // Reset pulsed mid-WAIT cancels the write; PSEL/PENABLE held afterwards must be ignored.
    @(negedge PCLK);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hFFFF0000;
    @(negedge PCLK);
    penable = 1'b1;
    PRESETn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset_pready%0d", i),  32'(pready[i]), 32'd0);
      check($sformatf("midreset_pslverr%0d", i), 32'(pslverr[i]), 32'd0);
      check($sformatf("midreset_prdata%0d", i),  prdata[i], 32'd0);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      seen = seen | pready[2];
    end
    check("d2_reset_no_resume", 32'(seen), 32'd0);
    bus_idle();
    xfer(2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    check("d2_reset_mem", rd, 32'h12345678);
    bus_idle();

`ifdef APB_MEM_PSTRB_EN
    // Byte strobes: partial write merges lanes, strobed read is an error.
    wr_strb = 4'hF;
    xfer(0, 1'b1, 32'h40, 32'h11223344, rd, er, lat);
    wr_strb = 4'b0101;
    xfer(0, 1'b1, 32'h40, 32'hAABBCCDD, rd, er, lat);
    check("strb_wr_pslverr", 32'(er), 32'd0);
    wr_strb = 4'hF;
    xfer(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
    check("strb_merge_data", rd, 32'h11BB33DD);
    rd_strb = 4'b0001;
    xfer(0, 1'b0, 32'h40, 32'h0, rd, er, lat);
    check("strb_rd_pslverr", 32'(er), 32'd1);
    check("strb_rd_prdata",  rd, 32'd0);
    rd_strb = 4'h0;
    bus_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
